// File: rtl/control_unit_pkg.sv
// Control-unit types shared by the hazard controller and its testbench.
package control_unit_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2,
    HALT  = 2'd3
  } hzd_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register-file index width.
package cpu_types_pkg;
  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] regbits_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
interface pipeline_hazard_ctrl_if;
  import cpu_types_pkg::*;

  logic        ihit, dhit;
  logic        dmemREN_mem, dmemWEN_mem;
  logic        memRd_ex;
  regbits_t    rd_ex, rs_id, rt_id;
  logic        jump_id, branch_ex, halt_wb;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush;
  logic        halted;
  logic [31:0] stall_cnt, flush_cnt;

  modport master (
    output ihit, dhit, dmemREN_mem, dmemWEN_mem, memRd_ex,
           rd_ex, rs_id, rt_id, jump_id, branch_ex, halt_wb,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, dmemREN_mem, dmemWEN_mem, memRd_ex,
           rd_ex, rs_id, rt_id, jump_id, branch_ex, halt_wb,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in ID/EX feeding a source in IF/ID.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     memRd_ex,
  input  regbits_t rd_ex,
  input  regbits_t rs_id,
  input  regbits_t rt_id,
  output logic     luse
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign luse = memRd_ex && (rd_ex != '0) && ((rd_ex == rs_id) || (rd_ex == rt_id));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush/halt controller. Define HAZARD_PERF_CNT_EN to build the
// stall/flush performance counters; otherwise the counter ports read constant 0.
module pipeline_hazard_ctrl
  import control_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  hzd_state_t state_q, state_d;
  logic       flush_if_p, flush_id_p;
  logic       dreq, advance, luse, go;
  logic       brk, jmp;

  assign dreq    = hz.dmemREN_mem | hz.dmemWEN_mem;
  assign advance = hz.ihit & (~dreq | hz.dhit);
  assign go      = ~rst & (state_q != HALT) & advance;
  assign brk     = hz.branch_ex | flush_id_p;
  assign jmp     = hz.jump_id | flush_if_p;

  load_use_detect u_lud (
    .memRd_ex (hz.memRd_ex),
    .rd_ex    (hz.rd_ex),
    .rs_id    (hz.rs_id),
    .rt_id    (hz.rt_id),
    .luse     (luse)
  );

  // Branch beats load-use; load-use beats jump, which simply re-resolves later.
  always_comb begin
    hz.pc_en      = 1'b0;
    hz.ifid_en    = 1'b0;
    hz.idex_en    = 1'b0;
    hz.exmem_en   = 1'b0;
    hz.memwb_en   = 1'b0;
    hz.ifid_flush = 1'b0;
    hz.idex_flush = 1'b0;
    if (go) begin
      hz.pc_en    = 1'b1;
      hz.ifid_en  = 1'b1;
      hz.idex_en  = 1'b1;
      hz.exmem_en = 1'b1;
      hz.memwb_en = 1'b1;
      if (brk) begin
        hz.ifid_flush = 1'b1;
        hz.idex_flush = 1'b1;
      end else if (luse) begin
        hz.pc_en      = 1'b0;
        hz.ifid_en    = 1'b0;
        hz.idex_flush = 1'b1;
      end else if (jmp) begin
        hz.ifid_flush = 1'b1;
      end
    end
  end

  assign hz.halted = ~rst & (state_q == HALT);

  always_comb begin
    state_d = state_q;
    if (state_q != HALT) begin
      if (advance && hz.halt_wb) begin
        state_d = HALT;
      end else begin
        case (state_q)
          RUN: begin
            if (dreq && !hz.dhit)  state_d = DWAIT;
            else if (!hz.ihit)     state_d = IWAIT;
          end
          DWAIT: begin
            if (hz.dhit)           state_d = hz.ihit ? RUN : IWAIT;
          end
          IWAIT: begin
            if (hz.ihit)           state_d = RUN;
          end
          default:                 state_d = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Control transfers seen while frozen are remembered until the pipe moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_if_p <= 1'b0;
      flush_id_p <= 1'b0;
    end else if (state_q != HALT) begin
      if (advance) begin
        flush_if_p <= 1'b0;
        flush_id_p <= 1'b0;
      end else begin
        flush_if_p <= flush_if_p | hz.branch_ex | hz.jump_id;
        flush_id_p <= flush_id_p | hz.branch_ex;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic        stall_evt;
  logic [31:0] stall_q, flush_q;

  assign stall_evt = (state_q != HALT) & (~advance | (luse & ~brk));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt)     stall_q <= stall_q + 32'd1;
      if (hz.ifid_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic against a behavioural model. Honours HAZARD_PERF_CNT_EN like the design.
module tb_pipeline_hazard_ctrl;
  import cpu_types_pkg::*;
  import control_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  hzd_state_t  mState;
  bit          mPendBr, mPendJp;
  logic [31:0] mStall, mFlush;
  bit          cAdv, cHaz, cBr, cJp, cDreq;

  function automatic logic [31:0] litCnt(input int n);
`ifdef HAZARD_PERF_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit ih, input bit dh, input bit ren, input bit wen,
                               input bit mr, input int rd, input int rs, input int rt,
                               input bit jp, input bit br, input bit hw);
    hz.ihit        = ih;
    hz.dhit        = dh;
    hz.dmemREN_mem = ren;
    hz.dmemWEN_mem = wen;
    hz.memRd_ex    = mr;
    hz.rd_ex       = regbits_t'(rd);
    hz.rs_id       = regbits_t'(rs);
    hz.rt_id       = regbits_t'(rt);
    hz.jump_id     = jp;
    hz.branch_ex   = br;
    hz.halt_wb     = hw;
  endtask

  // Expected outputs follow directly from the priority rules: branch > load-use > jump.
  task automatic checkOutput();
    bit moving;
    cDreq  = hz.dmemREN_mem || hz.dmemWEN_mem;
    cAdv   = hz.ihit && (!cDreq || hz.dhit);
    cHaz   = hz.memRd_ex && (hz.rd_ex != 0) && (hz.rd_ex == hz.rs_id || hz.rd_ex == hz.rt_id);
    cBr    = hz.branch_ex || mPendBr;
    cJp    = hz.jump_id || mPendJp;
    moving = !rst && (mState != HALT) && cAdv;
    checkVal("pc_en",      32'(hz.pc_en),      32'(moving && !(cHaz && !cBr)));
    checkVal("ifid_en",    32'(hz.ifid_en),    32'(moving && !(cHaz && !cBr)));
    checkVal("idex_en",    32'(hz.idex_en),    32'(moving));
    checkVal("exmem_en",   32'(hz.exmem_en),   32'(moving));
    checkVal("memwb_en",   32'(hz.memwb_en),   32'(moving));
    checkVal("ifid_flush", 32'(hz.ifid_flush), 32'(moving && (cBr || (cJp && !cHaz))));
    checkVal("idex_flush", 32'(hz.idex_flush), 32'(moving && (cBr || cHaz)));
    checkVal("halted",     32'(hz.halted),     32'(!rst && mState == HALT));
    checkVal("state",      32'(dut.state_q),   32'(mState));
    checkVal("stall_cnt",  hz.stall_cnt,       litCnt(int'(mStall)));
    checkVal("flush_cnt",  hz.flush_cnt,       litCnt(int'(mFlush)));
  endtask

  task automatic modelStep();
    if (mState == HALT) return;
    if (!cAdv || (cHaz && !cBr)) mStall = mStall + 32'd1;
    if (cAdv && (cBr || (cJp && !cHaz))) mFlush = mFlush + 32'd1;
    if (cAdv) begin
      mPendBr = 1'b0;
      mPendJp = 1'b0;
    end else begin
      mPendBr = mPendBr || hz.branch_ex;
      mPendJp = mPendJp || hz.jump_id;
    end
    if (cAdv && hz.halt_wb) mState = HALT;
    else if (mState == RUN && cDreq && !hz.dhit) mState = DWAIT;
    else if (mState == RUN && !hz.ihit) mState = IWAIT;
    else if (mState == DWAIT && hz.dhit) mState = hz.ihit ? RUN : IWAIT;
    else if (mState == IWAIT && hz.ihit) mState = RUN;
  endtask

  // Called just after a falling edge with inputs already applied; ends on the next falling edge.
  task automatic runCycle();
    #1;
    checkOutput();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic doReset();
    #2;
    rst = 1'b1;
    #1;
    mState  = RUN;
    mPendBr = 1'b0;
    mPendJp = 1'b0;
    mStall  = '0;
    mFlush  = '0;
    checkVal("rst_pc_en",     32'(hz.pc_en),      32'd0);
    checkVal("rst_memwb_en",  32'(hz.memwb_en),   32'd0);
    checkVal("rst_ifid_fl",   32'(hz.ifid_flush), 32'd0);
    checkVal("rst_halted",    32'(hz.halted),     32'd0);
    checkVal("rst_state",     32'(dut.state_q),   32'(RUN));
    checkVal("rst_stall_cnt", hz.stall_cnt,       32'd0);
    checkVal("rst_flush_cnt", hz.flush_cnt,       32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int haltCycles;
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    doReset();

    // Load-use on rs: one cycle of PC/IF-ID hold with a bubble into EX.
    applyStimulus(1, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0);
    #1;
    checkVal("lu_pc_en",      32'(hz.pc_en),      32'd0);
    checkVal("lu_ifid_en",    32'(hz.ifid_en),    32'd0);
    checkVal("lu_idex_flush", 32'(hz.idex_flush), 32'd1);
    runCycle();

    // Register 0 destination never stalls.
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    checkVal("r0_pc_en",  32'(hz.pc_en),  32'd1);
    checkVal("lu_stall",  hz.stall_cnt,   litCnt(1));
    runCycle();

    // Data miss for three cycles, then both hits.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkVal("dw_pc_en",    32'(hz.pc_en),    32'd0);
      checkVal("dw_memwb_en", 32'(hz.memwb_en), 32'd0);
      if (i > 0) checkVal("dw_state", 32'(dut.state_q), 32'(DWAIT));
      runCycle();
    end
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkVal("dw_done_en", 32'(hz.exmem_en), 32'd1);
    checkVal("dw_stall",   hz.stall_cnt,     litCnt(4));
    runCycle();

    // Branch arrives while fetch is stalled; flush is deferred to the resume cycle.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      checkVal("df_no_flush", 32'(hz.ifid_flush | hz.idex_flush), 32'd0);
      runCycle();
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkVal("df_state",      32'(dut.state_q),   32'(IWAIT));
    checkVal("df_ifid_flush", 32'(hz.ifid_flush), 32'd1);
    checkVal("df_idex_flush", 32'(hz.idex_flush), 32'd1);
    runCycle();

    // Branch overrides a simultaneous load-use.
    applyStimulus(1, 0, 0, 0, 1, 5, 5, 0, 0, 1, 0);
    #1;
    checkVal("pr_flush_cnt",  hz.flush_cnt,       litCnt(1));
    checkVal("pr_ifid_flush", 32'(hz.ifid_flush), 32'd1);
    checkVal("pr_idex_flush", 32'(hz.idex_flush), 32'd1);
    checkVal("pr_pc_en",      32'(hz.pc_en),      32'd1);
    runCycle();

    // Halt retires, then the core stays stopped until reset.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    runCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkVal("hl_halted", 32'(hz.halted), 32'd1);
      checkVal("hl_pc_en",  32'(hz.pc_en),  32'd0);
      checkVal("hl_stall",  hz.stall_cnt,   litCnt(6));
      checkVal("hl_flush",  hz.flush_cnt,   litCnt(2));
      runCycle();
    end
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkVal("post_rst_pc_en", 32'(hz.pc_en), 32'd1);
    runCycle();

    // Random traffic with small register indices so hazards are frequent.
    haltCycles = 0;
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 40) == 0);
      runCycle();
      haltCycles = (mState == HALT) ? haltCycles + 1 : 0;
      if (haltCycles >= 3 || $urandom_range(0, 80) == 0) begin
        doReset();
        haltCycles = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and reset is asynchronous and active-high: CLK input 1 (rising edge); RST input 1 (async, active-high).
REQ-002 Inputs SHALL be:
- ihit 1: instruction fetch complete.
- dhit 1: data access complete.
- dmemREN_mem 1, dmemWEN_mem 1: EX/MEM stage holds a load or store.
- memRd_ex 1: ID/EX stage holds a load.
- rd_ex regbits_t: load destination in ID/EX.
- rs_id regbits_t, rt_id regbits_t: sources in IF/ID.
- jump_id 1: jump resolved in ID.
- branch_ex 1: taken branch resolved in EX.
- halt_wb 1: halt in MEM/WB.
REQ-003 Outputs SHALL be:
- pc_en 1, ifid_en 1, idex_en 1, exmem_en 1, memwb_en 1: latch enables.
- ifid_flush 1, idex_flush 1: bubble inserts.
- halted 1: core stopped.
- stall_cnt 32, flush_cnt 32: performance counters.

Function
REQ-004 State machine SHALL be a registered enum with states RUN, DWAIT, IWAIT, HALT.
REQ-005 dreq = dmemREN_mem | dmemWEN_mem.
REQ-006 advance = ihit & (~dreq | dhit).
REQ-007 In RUN or IWAIT with advance=1: pc_en, ifid_en, idex_en, exmem_en, memwb_en SHALL all be 1, except as modified by REQ-011 to REQ-013.
REQ-008 advance=0 SHALL drive all five enables 0 that cycle (full freeze), with no flush asserted.
REQ-009 Transitions:
- RUN->DWAIT when dreq & ~dhit.
- RUN->IWAIT when ~ihit & ~(dreq & ~dhit).
- DWAIT->RUN on dhit & ihit.
- DWAIT->IWAIT on dhit & ~ihit.
- IWAIT->RUN on ihit.
- DWAIT and IWAIT SHALL drive outputs per REQ-007/REQ-008 from the live inputs.
REQ-010 Any state->HALT when halt_wb=1 and advance=1. HALT SHALL be absorbing: all enables 0, flushes 0, halted=1 until RST.
REQ-011 Load-use: memRd_ex & (rd_ex!=0) & (rd_ex==rs_id | rd_ex==rt_id) with advance=1 SHALL give pc_en=0, ifid_en=0, idex_flush=1 for exactly that cycle. The hazard clears the next cycle because the load has moved to EX/MEM.
REQ-012 branch_ex with advance=1 SHALL assert ifid_flush=1 and idex_flush=1; branch_ex SHALL override load-use in the same cycle.
REQ-013 jump_id with advance=1 SHALL assert ifid_flush=1; if load-use is also active, load-use wins and the jump re-resolves next cycle.
REQ-014 A flush request (branch_ex or jump_id) arriving with advance=0 SHALL set registered pending flags flush_if_p and flush_id_p, held until the next advance cycle. On that cycle the flags SHALL apply the flushes and then clear.
REQ-015 Flush outputs SHALL only assert in cycles where the matching enable would otherwise be 1; a flush never coincides with a freeze.
REQ-016 stall_cnt SHALL increment by 1 each cycle any of the following holds:
- advance=0 outside HALT; or
- load-use is asserted.
REQ-017 flush_cnt SHALL increment by 1 each cycle ifid_flush=1.
REQ-018 Both counters SHALL wrap modulo 2^32.

Reset
REQ-019 RST SHALL force, asynchronously:
- state RUN;
- pending flags 0;
- counters 0.
REQ-020 While RST=1: all enables 0, flushes 0, halted=0.
REQ-021 RST asserted mid-wait or in HALT SHALL return the block to RUN on the first CLK edge after deassertion.

Configuration
REQ-022 Macro HAZARD_PERF_CNT_EN:
- Defined: stall_cnt and flush_cnt SHALL behave per REQ-016 to REQ-018.
- Undefined: the counter registers SHALL be omitted, and the ports SHALL remain and be driven constant 0.

Structure
REQ-023 The hzd_state_t enum SHALL live in control_unit_pkg. regbits_t SHALL come from cpu_types_pkg.
REQ-024 The load-use comparator SHALL be a combinational sub-module, load_use_detect, with outputs luse 1.

Verification
REQ-025 Load-use: memRd_ex=1, rd_ex=5, rs_id=5, ihit=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt +1.
REQ-026 Register 0: rd_ex=0, rs_id=0, memRd_ex=1 -> no stall.
REQ-027 Data wait: dmemREN_mem=1, dhit=0 for 3 cycles -> all enables 0 for 3 cycles, state DWAIT. On dhit=1, ihit=1 -> enables 1, state RUN.
REQ-028 Deferred flush: branch_ex=1 while ihit=0 for 2 cycles -> no flush while frozen. On ihit=1 -> ifid_flush=1, idex_flush=1 in that single cycle; flush_cnt +1.
REQ-029 Halt: halt_wb=1, ihit=1 -> halted=1 next cycle, enables 0 indefinitely. RST pulse -> RUN, counters 0.
REQ-030 Priority: branch_ex=1 with load-use active -> ifid_flush=1, idex_flush=1, pc_en=1.
